// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_FINISH
  } cfg_state_t;

  function automatic int calc_nbytes(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

  function automatic int calc_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Sizing for the default 180-bit fabric chain
  localparam int CHAIN_LEN_DEF = 180;
  localparam int NBYTES        = calc_nbytes(CHAIN_LEN_DEF);
  localparam int CNT_W         = calc_cnt_w(CHAIN_LEN_DEF);

endpackage

// File: rtl/cfg_chain_loader_phase_timer.sv
// Half-period timer for prog_clk: flags the last of CLK_DIV cycles while running.
module cfg_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic phase_last_o
);

  localparam int PH_W = $clog2(CLK_DIV + 1);

  logic [PH_W-1:0] ph_q, ph_d;

  assign phase_last_o = run_i && (ph_q == PH_W'(CLK_DIV - 1));

  // Wraps at each half-period boundary so LO and HI both start from zero
  always_comb begin
    ph_d = ph_q + PH_W'(1);
    if (!run_i || phase_last_o) ph_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ph_q <= '0;
    else     ph_q <= ph_d;
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises a config bitstream into the fabric programming chain and
// assembles the displaced tail bits into readback bytes.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 180,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int BW = calc_cnt_w(CHAIN_LEN);

  cfg_state_t  state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  rb_sr_q, rb_sr_d, rb_byte;
  logic [7:0]  rb_data_q, rb_data_d;
  logic        rb_valid_q, rb_valid_d;
  logic        prog_in_q, prog_in_d;
  logic        prog_clk_q, prog_en_q, cfg_ready_q, busy_q, done_q;
  logic        phase_last, xfer, last_bit;

  cfg_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .run_i        ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI)),
    .phase_last_o (phase_last)
  );

  assign xfer        = cfg_valid & cfg_ready_q;
  assign bit_cnt_inc = bit_cnt_q + BW'(1);
  assign last_bit    = (bit_cnt_inc == BW'(CHAIN_LEN));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_d     = byte_q;
    rb_sr_d    = rb_sr_q;
    rb_byte    = rb_sr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    prog_in_d  = prog_in_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_FETCH;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        rb_sr_d   = '0;
      end
      ST_FETCH: if (xfer) begin
        byte_d    = cfg_data;
        prog_in_d = cfg_data[0];
        state_d   = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (phase_last) begin
        // Tail still holds the old bit: the chain only moves on the rising edge
        rb_byte[bit_idx_q] = prog_out;
        if (bit_idx_q == 3'd7 || last_bit) begin
          rb_data_d  = rb_byte;
          rb_valid_d = 1'b1;
          rb_sr_d    = '0;
        end else begin
          rb_sr_d = rb_byte;
        end
        state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: if (phase_last) begin
        bit_cnt_d = bit_cnt_inc;
        bit_idx_d = bit_idx_q + 3'd1;
        if (last_bit) begin
          state_d   = ST_FINISH;
          prog_in_d = 1'b0;
        end else if (bit_idx_q == 3'd7) begin
          state_d = ST_FETCH;
        end else begin
          byte_d    = {1'b0, byte_q[7:1]};
          prog_in_d = byte_q[1];
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_q      <= '0;
      rb_sr_q     <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      prog_in_q   <= 1'b0;
      prog_clk_q  <= 1'b0;
      prog_en_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_q      <= byte_d;
      rb_sr_q     <= rb_sr_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      prog_in_q   <= prog_in_d;
      // Outputs decoded from next state so they are flops aligned with state_q
      prog_clk_q  <= (state_d == ST_SHIFT_HI);
      prog_en_q   <= (state_d == ST_FETCH) || (state_d == ST_SHIFT_LO) ||
                     (state_d == ST_SHIFT_HI);
      cfg_ready_q <= (state_d == ST_FETCH);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FINISH);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign prog_clk  = prog_clk_q;
  assign prog_en   = prog_en_q;
  assign prog_in   = prog_in_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three parameterisations driven one at a time,
// each attached to a behavioural chain model.
module tb_cfg_chain_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic [2:0] start = 3'b000;
  wire  [2:0] rdy, pclk, pen, pin, rbv, busy, done, pout;
  wire  [7:0] rbd0, rbd1, rbd2;

  always #5 clk = ~clk;

  cfg_chain_loader #(.CHAIN_LEN(20), .CLK_DIV(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(rdy[0]), .prog_clk(pclk[0]), .prog_en(pen[0]), .prog_in(pin[0]),
    .prog_out(pout[0]), .rb_data(rbd0), .rb_valid(rbv[0]), .busy(busy[0]), .done(done[0]));

  cfg_chain_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(rdy[1]), .prog_clk(pclk[1]), .prog_en(pen[1]), .prog_in(pin[1]),
    .prog_out(pout[1]), .rb_data(rbd1), .rb_valid(rbv[1]), .busy(busy[1]), .done(done[1]));

  cfg_chain_loader #(.CHAIN_LEN(180), .CLK_DIV(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(rdy[2]), .prog_clk(pclk[2]), .prog_en(pen[2]), .prog_in(pin[2]),
    .prog_out(pout[2]), .rb_data(rbd2), .rb_valid(rbv[2]), .busy(busy[2]), .done(done[2]));

  // Chain models: shift in at the head on each prog_clk rise; tail is bit 0
  logic [19:0]  ch0 = 20'hABCDE;
  logic [7:0]   ch1 = 8'h00;
  logic [179:0] ch2 = '0;
  int rise0 = 0, rise1 = 0, rise2 = 0;

  assign pout = {ch2[0], ch1[0], ch0[0]};

  always @(posedge pclk[0]) begin ch0 <= {pin[0], ch0[19:1]};  rise0 <= rise0 + 1; end
  always @(posedge pclk[1]) begin ch1 <= {pin[1], ch1[7:1]};   rise1 <= rise1 + 1; end
  always @(posedge pclk[2]) begin ch2 <= {pin[2], ch2[179:1]}; rise2 <= rise2 + 1; end

  int busy_cnt = 0, done_cnt = 0, rb_n = 0;
  logic [7:0] rb_log [0:255];

  always @(posedge clk) begin
    if (|busy) busy_cnt <= busy_cnt + 1;
    if (|done) done_cnt <= done_cnt + 1;
    if (|rbv) begin
      rb_log[rb_n & 255] <= rbv[0] ? rbd0 : (rbv[1] ? rbd1 : rbd2);
      rb_n <= rb_n + 1;
    end
  end

  int checks = 0, errors = 0;
  logic [7:0] stim [0:22];

  task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [179:0] chain_of(input int k);
    case (k)
      0:       return 180'(ch0);
      1:       return 180'(ch1);
      default: return ch2;
    endcase
  endfunction

  function automatic int rise_of(input int k);
    case (k)
      0:       return rise0;
      1:       return rise1;
      default: return rise2;
    endcase
  endfunction

  task automatic send_byte(input int k, input logic [7:0] b, input int gap);
    int t;
    cfg_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      if (rdy[k]) begin
        chk("gap_prog_clk", 180'(pclk[k]), 180'(0));
        chk("gap_prog_en", 180'(pen[k]), 180'(1));
      end
    end
    cfg_data  = b;
    cfg_valid = 1'b1;
    t = 0;
    while (!rdy[k] && t < 2000) begin tick(); t++; end
    chk("fetch_wait", 180'(rdy[k]), 180'(1));
    tick();
    cfg_valid = 1'b0;
  endtask

  // gap_max < 0: fixed gap of -gap_max; > 0: random gap up to gap_max
  task automatic run_load(input int k, input int len, input int nb, input int gap_max,
                          input bit poke, output int busy_cycles);
    logic [179:0] old, exp;
    logic [7:0]   e8;
    int d0, r0, b0, t, gap;
    old = chain_of(k);
    d0 = done_cnt; r0 = rb_n; b0 = busy_cnt;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      gap = (gap_max < 0) ? -gap_max : ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      send_byte(k, stim[i], gap);
      if (poke && i == 0) begin
        start[k] = 1'b1; cfg_valid = 1'b1; cfg_data = ~stim[1];
        tick();
        chk("ready_while_shift", 180'(rdy[k]), 180'(0));
        chk("busy_while_shift", 180'(busy[k]), 180'(1));
        start[k] = 1'b0; cfg_valid = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin tick(); t++; end
    tick(); tick();
    exp = '0;
    for (int j = 0; j < len; j++) exp[j] = stim[j / 8][j % 8];
    chk("chain", chain_of(k), exp);
    chk("done_count", 180'(done_cnt - d0), 180'(1));
    chk("rb_count", 180'(rb_n - r0), 180'(nb));
    for (int i = 0; i < nb; i++) begin
      e8 = 8'h00;
      for (int b = 0; b < 8; b++) if (i * 8 + b < len) e8[b] = old[i * 8 + b];
      chk("rb_byte", 180'(rb_log[(r0 + i) & 255]), 180'(e8));
    end
    busy_cycles = busy_cnt - b0;
  endtask

  initial begin
    int bc, r, d;
    repeat (3) tick();
    chk("rst_busy", 180'(busy), 180'(0));
    chk("rst_done", 180'(done), 180'(0));
    chk("rst_ready", 180'(rdy), 180'(0));
    chk("rst_prog", 180'({pclk, pen, pin}), 180'(0));
    chk("rst_rb", 180'({rbv, rbd0, rbd1, rbd2}), 180'(0));
    rst = 1'b0;
    tick();

    // T1: back-to-back load into a preloaded 20-bit chain
    stim[0] = 8'h5A; stim[1] = 8'hC3; stim[2] = 8'h0F;
    run_load(0, 20, 3, 0, 1'b0, bc);
    chk("t1_chain_value", 180'(ch0), 180'(20'hFC35A));
    chk("t1_busy_cycles", 180'(bc), 180'(84));

    // T2: same bytes with 10-cycle stalls; readback is now the T1 image
    run_load(0, 20, 3, -10, 1'b0, bc);
    chk("t2_chain_value", 180'(ch0), 180'(20'hFC35A));

    // T3: CLK_DIV=1, single byte
    stim[0] = 8'h81;
    r = rise_of(1);
    run_load(1, 8, 1, 0, 1'b0, bc);
    chk("t3_rises", 180'(rise_of(1) - r), 180'(8));
    chk("t3_busy_cycles", 180'(bc), 180'(18));
    chk("t3_chain_value", 180'(ch1), 180'(8'h81));

    // T4: reset in the middle of the second byte
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    send_byte(0, 8'h33, 0);
    send_byte(0, 8'hCC, 0);
    repeat (6) tick();
    rst = 1'b1;
    d = done_cnt;
    tick();
    chk("abort_outputs", 180'({rdy[0], pclk[0], pen[0], pin[0], rbv[0], busy[0], done[0]}), 180'(0));
    chk("abort_rb_data", 180'(rbd0), 180'(0));
    rst = 1'b0;
    repeat (20) tick();
    chk("abort_no_done", 180'(done_cnt - d), 180'(0));
    chk("abort_idle", 180'(busy[0]), 180'(0));
    for (int i = 0; i < 3; i++) stim[i] = 8'($urandom);
    run_load(0, 20, 3, 2, 1'b0, bc);

    // T5: cfg_valid in IDLE is ignored; start mid-load is ignored
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", 180'(rdy[0]), 180'(0));
      chk("idle_busy", 180'(busy[0]), 180'(0));
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) stim[i] = 8'($urandom);
    run_load(0, 20, 3, 0, 1'b1, bc);
    chk("t5_busy_cycles", 180'(bc), 180'(84));

    // T6: random 180-bit bitstreams with random valid gaps
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 23; i++) stim[i] = 8'($urandom);
      run_load(2, 180, 23, 4, 1'b0, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
